// File: rtl/icache_pkg.sv
// Shared constants, derived-width helpers and FSM state type for the
// N-way instruction cache.
package icache_pkg;

   // Width of one instruction word on the fetch and refill buses.
   localparam int BUS_W = 32;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      MISS  = 2'd1,
      FLUSH = 2'd2
   } state_t;

   // Byte-offset bits covering one line (word select plus byte-in-word).
   function automatic int off_w(input int line_words);
      return $clog2(line_words) + 2;
   endfunction

   // Set-index bits.
   function automatic int idx_w(input int sets);
      return $clog2(sets);
   endfunction

   // Remaining upper address bits form the tag.
   function automatic int tag_w(input int addr_w, input int sets, input int line_words);
      return addr_w - idx_w(sets) - off_w(line_words);
   endfunction

endpackage

// File: rtl/icache_nway_if.sv
// Fetch-side and refill-side signal bundle of the instruction cache.
//
// Handshakes:
//  - Fetch: Req is a request qualifier; the cache answers in the same cycle
//    with RValid (data in RData) or Stall. While Stall=1 the requester holds
//    Req and PAddr stable; the request completes in the first cycle RValid=1.
//  - Refill: MemReq/MemAddr are held by the cache until a single-beat MemAck
//    carrying the whole line in MemData; MemReq drops the cycle after MemAck.
//    MemAck is ignored whenever MemReq is low.
//  - Flush: single-cycle pulse, no acknowledge.
interface icache_nway_if #(
   parameter int ADDR_W     = 32,
   parameter int LINE_WORDS = 4
);
   import icache_pkg::*;

   logic                        Req;
   logic [ADDR_W-1:0]           PAddr;
   logic [BUS_W-1:0]            RData;
   logic                        RValid;
   logic                        Stall;
   logic                        Flush;
   logic                        MemReq;
   logic [ADDR_W-1:0]           MemAddr;
   logic                        MemAck;
   logic [BUS_W*LINE_WORDS-1:0] MemData;

   // Fetch unit plus memory side, as seen from outside the cache.
   modport master (
      output Req, PAddr, Flush, MemAck, MemData,
      input  RData, RValid, Stall, MemReq, MemAddr
   );

   // The cache itself.
   modport slave (
      input  Req, PAddr, Flush, MemAck, MemData,
      output RData, RValid, Stall, MemReq, MemAddr
   );

endinterface

// File: rtl/icache_lru.sv
// True-LRU helper for one set: picks the refill victim and computes the
// age vector after an access. Age 0 is most recently used.
module icache_lru
   import icache_pkg::*;
#(
   parameter  int WAYS  = 4,
   localparam int WAY_W = $clog2(WAYS)
) (
   input  logic [WAYS-1:0][WAY_W-1:0] ages,
   input  logic [WAYS-1:0]            valids,
   input  logic [WAY_W-1:0]           acc_way,
   output logic [WAYS-1:0][WAY_W-1:0] new_ages,
   output logic [WAY_W-1:0]           victim
);

   logic             found_inv;
   logic [WAY_W-1:0] acc_age;

   // Victim: lowest invalid way, otherwise the way holding the oldest age.
   always_comb begin
      victim    = '0;
      found_inv = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (!valids[w] && !found_inv) begin
            victim    = WAY_W'(w);
            found_inv = 1'b1;
         end
      end
      if (!found_inv) begin
         for (int w = 0; w < WAYS; w++) begin
            if (ages[w] == WAY_W'(WAYS - 1)) victim = WAY_W'(w);
         end
      end
   end

   // Accessed way becomes MRU; ways younger than it age by one.
   always_comb begin
      acc_age = ages[acc_way];
      for (int w = 0; w < WAYS; w++) begin
         if (WAY_W'(w) == acc_way)       new_ages[w] = '0;
         else if (ages[w] < acc_age)     new_ages[w] = ages[w] + WAY_W'(1);
         else                            new_ages[w] = ages[w];
      end
   end

endmodule

// File: rtl/icache_nway.sv
// N-way set-associative instruction cache: combinational hits, single-line
// refill on miss, whole-cache invalidate, true-LRU replacement.
module icache_nway
   import icache_pkg::*;
#(
   parameter int WAYS       = 4,
   parameter int SETS       = 64,
   parameter int LINE_WORDS = 4,
   parameter int ADDR_W     = 32
) (
   input  logic              Clk,
   input  logic              Rst,
   icache_nway_if.slave      bus,
   output state_t            DbgState
);

   localparam int OFF_W  = off_w(LINE_WORDS);
   localparam int IDX_W  = idx_w(SETS);
   localparam int TAG_W  = tag_w(ADDR_W, SETS, LINE_WORDS);
   localparam int WAY_W  = $clog2(WAYS);
   localparam int WORD_W = $clog2(LINE_WORDS);
   localparam int LINE_W = BUS_W * LINE_WORDS;
   localparam int LA_W   = ADDR_W - OFF_W;

   state_t                  state_q, state_d;
   logic                    flush_pend_q, flush_pend_d;
   logic [LA_W-1:0]         miss_line_q, miss_line_d;

   logic [TAG_W-1:0]        req_tag;
   logic [IDX_W-1:0]        req_idx;
   logic [WORD_W-1:0]       req_word;
   logic [TAG_W-1:0]        miss_tag;
   logic [IDX_W-1:0]        miss_idx;
   logic [IDX_W-1:0]        set_idx;

   logic [WAYS-1:0]            rd_vld;
   logic [TAG_W-1:0]           rd_tag  [WAYS];
   logic [LINE_W-1:0]          rd_line [WAYS];
   logic [WAYS-1:0][WAY_W-1:0] rd_age;
   logic [WAYS-1:0][WAY_W-1:0] new_ages;
   logic [WAY_W-1:0]           victim;
   logic [WAY_W-1:0]           acc_way;

   logic                    hit;
   logic [WAY_W-1:0]        hit_way;
   logic [LINE_W-1:0]       hit_line;
   logic [BUS_W-1:0]        hit_word;
   logic                    rvalid;
   logic                    mem_req;
   logic [ADDR_W-1:0]       mem_addr;
   logic                    fill_we;
   logic                    age_we;
   logic                    flush_clr;
   logic                    unused_addr_bits;

   assign req_tag  = bus.PAddr[ADDR_W-1 -: TAG_W];
   assign req_idx  = bus.PAddr[OFF_W +: IDX_W];
   assign req_word = bus.PAddr[2 +: WORD_W];
   assign miss_tag = miss_line_q[IDX_W +: TAG_W];
   assign miss_idx = miss_line_q[IDX_W-1:0];
   assign unused_addr_bits = ^bus.PAddr[1:0];

   // During a refill the set is taken from the latched miss address.
   assign set_idx   = (state_q == MISS) ? miss_idx : req_idx;
   assign fill_we   = (state_q == MISS) && bus.MemAck;
   assign age_we    = rvalid || fill_we;
   assign flush_clr = (state_q == FLUSH);
   assign acc_way   = (state_q == MISS) ? victim : hit_way;

   // Per-way storage; only valid bits and ages need a reset value.
   for (genvar w = 0; w < WAYS; w++) begin : g_way
      logic [SETS-1:0]   vld_q;
      logic [TAG_W-1:0]  tag_q  [SETS];
      logic [LINE_W-1:0] line_q [SETS];
      logic [WAY_W-1:0]  age_q  [SETS];

      // Valid bits and LRU ages; flush clears valids but keeps ages.
      always_ff @(posedge Clk) begin
         if (Rst) begin
            vld_q <= '0;
            for (int s = 0; s < SETS; s++) age_q[s] <= WAY_W'(w);
         end else begin
            if (flush_clr)                              vld_q          <= '0;
            else if (fill_we && victim == WAY_W'(w))    vld_q[set_idx] <= 1'b1;
            if (age_we) age_q[set_idx] <= new_ages[w];
         end
      end

      // Tag and line data written only on a refill into this way.
      always_ff @(posedge Clk) begin
         if (fill_we && victim == WAY_W'(w)) begin
            tag_q[set_idx]  <= miss_tag;
            line_q[set_idx] <= bus.MemData;
         end
      end

      assign rd_vld[w]  = vld_q[set_idx];
      assign rd_tag[w]  = tag_q[set_idx];
      assign rd_line[w] = line_q[set_idx];
      assign rd_age[w]  = age_q[set_idx];
   end

   icache_lru #(.WAYS(WAYS)) u_lru (
      .ages     (rd_age),
      .valids   (rd_vld),
      .acc_way  (acc_way),
      .new_ages (new_ages),
      .victim   (victim)
   );

   // Tag compare; scanning downward leaves the lowest matching way selected.
   always_comb begin
      hit     = 1'b0;
      hit_way = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (rd_vld[w] && rd_tag[w] == req_tag) begin
            hit     = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
   end

   // Word select out of the hitting line.
   always_comb begin
      hit_line = rd_line[hit_way];
      hit_word = '0;
      for (int i = 0; i < LINE_WORDS; i++) begin
         if (req_word == WORD_W'(i)) hit_word = hit_line[i*BUS_W +: BUS_W];
      end
   end

   // FSM state, pending-flush flag and latched miss line address.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_q      <= IDLE;
         flush_pend_q <= 1'b0;
         miss_line_q  <= '0;
      end else begin
         state_q      <= state_d;
         flush_pend_q <= flush_pend_d;
         miss_line_q  <= miss_line_d;
      end
   end

   // Next state and outputs; a flush always wins over a fetch.
   always_comb begin
      state_d      = state_q;
      flush_pend_d = flush_pend_q;
      miss_line_d  = miss_line_q;
      rvalid       = 1'b0;
      mem_req      = 1'b0;
      mem_addr     = '0;
      unique case (state_q)
         IDLE: begin
            if (bus.Flush) begin
               state_d = FLUSH;
            end else if (bus.Req) begin
               if (hit) begin
                  rvalid = 1'b1;
               end else begin
                  state_d     = MISS;
                  miss_line_d = bus.PAddr[ADDR_W-1:OFF_W];
               end
            end
         end
         MISS: begin
            mem_req  = 1'b1;
            mem_addr = {miss_line_q, {OFF_W{1'b0}}};
            if (bus.Flush) flush_pend_d = 1'b1;
            if (bus.MemAck) begin
               state_d      = (flush_pend_q || bus.Flush) ? FLUSH : IDLE;
               flush_pend_d = 1'b0;
            end
         end
         FLUSH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.RValid  = rvalid;
   assign bus.Stall   = bus.Req && !rvalid;
   assign bus.RData   = rvalid ? hit_word : '0;
   assign bus.MemReq  = mem_req;
   assign bus.MemAddr = mem_addr;
   assign DbgState    = state_q;

endmodule
